// File: rtl/tx_serializer_10b.sv
// -----------------------------------------------------------------------------
// tx_serializer_10b
//
// Serializes 10-bit 8B/10B symbols onto a single line, MSB (bit 9, "a") first,
// and tracks the running disparity of the transmitted stream.
//
// Ports
//   CLK         in   clock, all state updates on the rising edge
//   RST_N       in   asynchronous active-low reset
//   SYM_I       in   [9:0] encoded symbol, bit 9 = a ... bit 0 = j
//   SYM_VLD_I   in   SYM_I valid
//   SYM_RDY_O   out  symbol can be accepted this cycle (depends on state only)
//   SER_O       out  registered serial line bit
//   RD_O        out  running disparity, 0 = RD-, 1 = RD+ (feeds encoder RD_I)
//   DISP_ERR_O  out  one-cycle pulse after accepting a disparity-illegal symbol
//
// Parameter
//   COMMA_RDN   K28.5 RD- symbol; the RD+ comma is its bitwise inverse
//
// Build option
//   TX_IDLE_COMMA_EN  when defined, gaps between data symbols are filled with
//                     commas of the correct disparity, and the line never
//                     returns to idle after the first symbol (only reset does).
//                     When undefined, gaps drive the line low via IDLE.
// -----------------------------------------------------------------------------
module tx_serializer_10b #(
  parameter logic [9:0] COMMA_RDN = 10'b0011111010
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [9:0] SYM_I,
  input  logic       SYM_VLD_I,
  output logic       SYM_RDY_O,
  output logic       SER_O,
  output logic       RD_O,
  output logic       DISP_ERR_O
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef TX_IDLE_COMMA_EN
    ST_COMMA = 2'd2,
`endif
    ST_DATA  = 2'd1
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'd9;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] shreg_q, shreg_d;
  logic       ser_q, ser_d;
  logic       rd_q, rd_d;
  logic       derr_q, derr_d;

  logic       xfer;
  logic [3:0] sym_ones;

  // Number of ones in a 10-bit symbol.
  function automatic logic [3:0] ones_cnt(input logic [9:0] s);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'b000, s[i]};
    end
    return n;
  endfunction

  // Running disparity after sending a symbol with n ones: more ones than
  // zeros leaves the line RD+, fewer leaves it RD-, balanced keeps it.
  function automatic logic rd_after(input logic rd, input logic [3:0] n);
    logic r;
    r = rd;
    if (n > 4'd5) begin
      r = 1'b1;
    end else if (n < 4'd5) begin
      r = 1'b0;
    end
    return r;
  endfunction

  // A legal symbol has 4, 5 or 6 ones, and an unbalanced symbol must push
  // the disparity back toward the opposite sign (6 ones only from RD-,
  // 4 ones only from RD+).
  function automatic logic disp_illegal(input logic rd, input logic [3:0] n);
    logic bad;
    bad = 1'b0;
    if ((n != 4'd4) && (n != 4'd5) && (n != 4'd6)) begin
      bad = 1'b1;
    end else if ((n == 4'd6) && rd) begin
      bad = 1'b1;
    end else if ((n == 4'd4) && !rd) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

`ifdef TX_IDLE_COMMA_EN
  // Comma matching the current disparity.
  function automatic logic [9:0] comma_sel(input logic rd);
    return rd ? ~COMMA_RDN : COMMA_RDN;
  endfunction

  logic [9:0] comma_sym;
  assign comma_sym = comma_sel(rd_q);
`endif

  // Ready while idle, or while the last bit of the current symbol is on the
  // line so the next symbol follows without a gap.
  assign SYM_RDY_O = (state_q == ST_IDLE) || (cnt_q == LAST_BIT);
  assign xfer      = SYM_VLD_I && SYM_RDY_O;
  assign sym_ones  = ones_cnt(SYM_I);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    ser_d   = 1'b0;
    rd_d    = rd_q;
    derr_d  = 1'b0;

    if (xfer) begin
      // Bit 9 goes straight to the output register so it appears in the
      // cycle after the load edge; the shift register keeps the full symbol
      // and bit 8 onward is taken from it.
      state_d = ST_DATA;
      cnt_d   = 4'd0;
      shreg_d = SYM_I;
      ser_d   = SYM_I[9];
      rd_d    = rd_after(rd_q, sym_ones);
      derr_d  = disp_illegal(rd_q, sym_ones);
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = 4'd0;
          shreg_d = 10'd0;
        end
`ifdef TX_IDLE_COMMA_EN
        ST_DATA, ST_COMMA: begin
`else
        ST_DATA: begin
`endif
          if (cnt_q == LAST_BIT) begin
`ifdef TX_IDLE_COMMA_EN
            // Gap fill: commas are never flagged as disparity errors.
            state_d = ST_COMMA;
            cnt_d   = 4'd0;
            shreg_d = comma_sym;
            ser_d   = comma_sym[9];
            rd_d    = rd_after(rd_q, ones_cnt(comma_sym));
`else
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            shreg_d = 10'd0;
`endif
          end else begin
            ser_d   = shreg_q[8];
            shreg_d = {shreg_q[8:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          shreg_d = 10'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      shreg_q <= 10'd0;
      ser_q   <= 1'b0;
      rd_q    <= 1'b0;
      derr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ser_q   <= ser_d;
      rd_q    <= rd_d;
      derr_q  <= derr_d;
    end
  end

  assign SER_O      = ser_q;
  assign RD_O       = rd_q;
  assign DISP_ERR_O = derr_q;

endmodule
